// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundles the opcode field and every DataPath control strobe driven by the
//   sequencer, so the sequencer and DataPath connect through one port.
//
//   There is no valid/ready handshake on this bus. Every strobe is a level
//   signal that is valid for one whole clock cycle, which is one T-state.
//   opcode is sampled only on the clock edge that leaves T2.
//
//   Signals:
//     opcode[4:0]       IR[31:27] from DataPath.
//     PCout .. IRin     fetch and memory strobes.
//     Yin .. BAout      ALU-path strobes.
//     Gra .. Rout       register-select strobes.
//     aluControl[4:0]   ALU operation code.
//     run               high while an instruction is sequencing.
//   Modports:
//     master   the sequencer (drives strobes, reads opcode).
//     slave    the DataPath side.
interface control_unit_if;
  logic [4:0] opcode;
  logic       PCout;
  logic       IncPC;
  logic       MARin;
  logic       MDRin;
  logic       MDRout;
  logic       read;
  logic       RAMenable;
  logic       IRin;
  logic       Yin;
  logic       ZLOin;
  logic       ZLOout;
  logic       ZHIout;
  logic       Cout;
  logic       BAout;
  logic       Gra;
  logic       Grb;
  logic       Grc;
  logic       Rin;
  logic       Rout;
  logic [4:0] aluControl;
  logic       run;

  modport master (
    input  opcode,
    output PCout, IncPC, MARin, MDRin, MDRout, read, RAMenable, IRin,
    output Yin, ZLOin, ZLOout, ZHIout, Cout, BAout,
    output Gra, Grb, Grc, Rin, Rout,
    output aluControl, run
  );

  modport slave (
    output opcode,
    input  PCout, IncPC, MARin, MDRin, MDRout, read, RAMenable, IRin,
    input  Yin, ZLOin, ZLOout, ZHIout, Cout, BAout,
    input  Gra, Grb, Grc, Rin, Rout,
    input  aluControl, run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit
//   This is the Moore sequencing FSM for the Mini-SRC instruction subset. It
//   fetches an instruction in T0..T2 and captures the opcode on the edge that
//   leaves T2. It then runs the execute states for that opcode and returns to
//   T0. A halt instruction parks the FSM in HALT until clear is asserted.
//   All outputs are decoded from state_q and op_q only.
//
//   Ports:
//     clock    in   system clock; every state change happens on posedge.
//     clear    in   synchronous active-high reset. It forces RST and op_q=0.
//     bus      master modport of control_unit_if (opcode in, strobes out).
//     state_o  out  current state register, exposed for debug.
module control_unit (
  input  logic                  clock,
  input  logic                  clear,
  control_unit_if.master        bus,
  output logic [3:0]            state_o
);

  // State encoding
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Opcode map
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // The ALU add code is used for the effective-address and immediate adds.
  localparam logic [4:0] ALU_ADD = 5'b00011;

  logic [3:0] state_q, state_d;
  logic [4:0] op_q, op_d;

  // Opcode classes of the latched instruction
  logic is_alu3, is_addi, is_ld, is_muldiv;

  always_comb begin
    is_alu3   = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                (op_q == OP_AND) || (op_q == OP_OR);
    is_addi   = (op_q == OP_ADDI);
    is_ld     = (op_q == OP_LD);
    is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2: begin
        state_d = S_T3;
        // IR is loaded during T2, so the opcode is valid on this edge.
        op_d    = bus.opcode;
      end
      S_T3: begin
        if (op_q == OP_HALT)
          state_d = S_HALT;
        else if (is_alu3 || is_addi || is_ld || is_muldiv)
          state_d = S_T4;
        else
          state_d = S_T0;  // mfhi, mflo, nop and unknown opcodes end here
      end
      S_T4:   state_d = is_muldiv ? S_T0 : S_T5;
      S_T5:   state_d = is_ld ? S_T6 : S_T0;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;  // unused encodings recover through RST
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_RST;
      op_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Output decode
  logic       pc_out, inc_pc, mar_in, mdr_in, mdr_out, rd, ram_en, ir_in;
  logic       y_in, zlo_in, zlo_out, zhi_out, c_out, ba_out;
  logic       gra, grb, grc, r_in, r_out;
  logic [4:0] alu_ctl;
  logic       run_w;

  always_comb begin
    pc_out  = 1'b0;
    inc_pc  = 1'b0;
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    mdr_out = 1'b0;
    rd      = 1'b0;
    ram_en  = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    zlo_in  = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    c_out   = 1'b0;
    ba_out  = 1'b0;
    gra     = 1'b0;
    grb     = 1'b0;
    grc     = 1'b0;
    r_in    = 1'b0;
    r_out   = 1'b0;
    alu_ctl = 5'd0;
    run_w   = (state_q >= S_T0) && (state_q <= S_T7);
    case (state_q)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
      end
      S_T1: begin
        rd     = 1'b1;
        ram_en = 1'b1;
        mdr_in = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_alu3 || is_addi) begin
          grb   = 1'b1;
          r_out = 1'b1;
          y_in  = 1'b1;
        end else if (is_ld) begin
          // Base register goes through BAout so that R0 reads as zero.
          grb    = 1'b1;
          ba_out = 1'b1;
          y_in   = 1'b1;
        end else if (is_muldiv) begin
          gra   = 1'b1;
          r_out = 1'b1;
          y_in  = 1'b1;
        end else if (op_q == OP_MFHI) begin
          zhi_out = 1'b1;
          gra     = 1'b1;
          r_in    = 1'b1;
        end else if (op_q == OP_MFLO) begin
          zlo_out = 1'b1;
          gra     = 1'b1;
          r_in    = 1'b1;
        end
      end
      S_T4: begin
        zlo_in = 1'b1;
        if (is_alu3) begin
          grc     = 1'b1;
          r_out   = 1'b1;
          alu_ctl = op_q;
        end else if (is_muldiv) begin
          grb     = 1'b1;
          r_out   = 1'b1;
          alu_ctl = op_q;
        end else begin
          // addi and ld both add the sign-extended constant from C.
          c_out   = 1'b1;
          alu_ctl = ALU_ADD;
        end
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (is_ld) begin
          mar_in = 1'b1;
        end else begin
          gra  = 1'b1;
          r_in = 1'b1;
        end
      end
      S_T6: begin
        rd     = 1'b1;
        ram_en = 1'b1;
        mdr_in = 1'b1;
      end
      S_T7: begin
        mdr_out = 1'b1;
        gra     = 1'b1;
        r_in    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.PCout      = pc_out;
  assign bus.IncPC      = inc_pc;
  assign bus.MARin      = mar_in;
  assign bus.MDRin      = mdr_in;
  assign bus.MDRout     = mdr_out;
  assign bus.read       = rd;
  assign bus.RAMenable  = ram_en;
  assign bus.IRin       = ir_in;
  assign bus.Yin        = y_in;
  assign bus.ZLOin      = zlo_in;
  assign bus.ZLOout     = zlo_out;
  assign bus.ZHIout     = zhi_out;
  assign bus.Cout       = c_out;
  assign bus.BAout      = ba_out;
  assign bus.Gra        = gra;
  assign bus.Grb        = grb;
  assign bus.Grc        = grc;
  assign bus.Rin        = r_in;
  assign bus.Rout       = r_out;
  assign bus.aluControl = alu_ctl;
  assign bus.run        = run_w;
  assign state_o        = state_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  // Bit positions of the packed output word
  localparam logic [24:0] PCOUT  = 25'(1) << 24;
  localparam logic [24:0] INCPC  = 25'(1) << 23;
  localparam logic [24:0] MARIN  = 25'(1) << 22;
  localparam logic [24:0] MDRIN  = 25'(1) << 21;
  localparam logic [24:0] MDROUT = 25'(1) << 20;
  localparam logic [24:0] READ   = 25'(1) << 19;
  localparam logic [24:0] RAMEN  = 25'(1) << 18;
  localparam logic [24:0] IRIN   = 25'(1) << 17;
  localparam logic [24:0] YIN    = 25'(1) << 16;
  localparam logic [24:0] ZLOIN  = 25'(1) << 15;
  localparam logic [24:0] ZLOOUT = 25'(1) << 14;
  localparam logic [24:0] ZHIOUT = 25'(1) << 13;
  localparam logic [24:0] COUT   = 25'(1) << 12;
  localparam logic [24:0] BAOUT  = 25'(1) << 11;
  localparam logic [24:0] GRA    = 25'(1) << 10;
  localparam logic [24:0] GRB    = 25'(1) << 9;
  localparam logic [24:0] GRC    = 25'(1) << 8;
  localparam logic [24:0] RIN    = 25'(1) << 7;
  localparam logic [24:0] ROUT   = 25'(1) << 6;
  localparam logic [24:0] RUN    = 25'(1);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_UNK  = 5'b11111;

  localparam logic [24:0] E_T0 = PCOUT | MARIN | INCPC | RUN;
  localparam logic [24:0] E_T1 = READ | RAMEN | MDRIN | RUN;
  localparam logic [24:0] E_T2 = MDROUT | IRIN | RUN;

  // Clock/reset block
  logic       clk;
  logic       clear;
  logic [3:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clock   (clk),
    .clear   (clear),
    .bus     (bus.master),
    .state_o (state_dbg)
  );

  // Scoreboard
  logic [24:0] exp_q[$];
  string       tag_q[$];
  int          n_checks;
  int          n_fail;
  logic        mon_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] alu(input logic [4:0] code);
    return {19'd0, code, 1'b0};
  endfunction

  logic [24:0] dut_word;
  assign dut_word = {bus.PCout, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                     bus.read, bus.RAMenable, bus.IRin,
                     bus.Yin, bus.ZLOin, bus.ZLOout, bus.ZHIout, bus.Cout, bus.BAout,
                     bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                     bus.aluControl, bus.run};

  // Monitor: outputs settle after posedge, compared on negedge
  always @(negedge clk) begin
    logic [31:0] exp_w;
    string       t;
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        exp_w = {7'd0, exp_q.pop_front()};
        t     = tag_q.pop_front();
      end else begin
        exp_w = 32'hFFFF_FFFF;
        t     = "sb_underflow";
      end
      check_eq(t, {7'd0, dut_word}, exp_w);
    end
  end

  // Driver tasks: one call is one clock cycle. exp is the output word for
  // the state entered on the posedge that the call waits for.
  task automatic drive(input logic clr, input logic [4:0] op, input logic [24:0] exp,
                       input string tag);
    clear      = clr;
    bus.opcode = op;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_op();
    return 5'($urandom_range(0, 31));
  endfunction

  // Opcode is randomized everywhere except the edge leaving T2.
  task automatic fetch(input string name);
    drive(1'b0, rnd_op(), E_T0, {name, ".T0"});
    drive(1'b0, rnd_op(), E_T1, {name, ".T1"});
    drive(1'b0, rnd_op(), E_T2, {name, ".T2"});
  endtask

  task automatic do_alu3(input logic [4:0] op, input string name);
    fetch(name);
    drive(1'b0, op,        GRB | ROUT | YIN | RUN,             {name, ".T3"});
    drive(1'b0, rnd_op(),  GRC | ROUT | ZLOIN | alu(op) | RUN, {name, ".T4"});
    drive(1'b0, rnd_op(),  ZLOOUT | GRA | RIN | RUN,           {name, ".T5"});
  endtask

  task automatic do_ld(input string name);
    fetch(name);
    drive(1'b0, OP_LD,    GRB | BAOUT | YIN | RUN,                {name, ".T3"});
    drive(1'b0, rnd_op(), COUT | ZLOIN | alu(OP_ADD) | RUN,       {name, ".T4"});
    drive(1'b0, rnd_op(), ZLOOUT | MARIN | RUN,                   {name, ".T5"});
    drive(1'b0, rnd_op(), READ | RAMEN | MDRIN | RUN,             {name, ".T6"});
    drive(1'b0, rnd_op(), MDROUT | GRA | RIN | RUN,               {name, ".T7"});
  endtask

  task automatic do_muldiv(input logic [4:0] op, input string name);
    fetch(name);
    drive(1'b0, op,       GRA | ROUT | YIN | RUN,             {name, ".T3"});
    drive(1'b0, rnd_op(), GRB | ROUT | ZLOIN | alu(op) | RUN, {name, ".T4"});
  endtask

  task automatic do_short(input logic [4:0] op, input logic [24:0] t3, input string name);
    fetch(name);
    drive(1'b0, op, t3 | RUN, {name, ".T3"});
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    mon_en     = 1'b0;
    clear      = 1'b1;
    bus.opcode = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b1;

    drive(1'b1, OP_ADD, 25'd0, "rst");

    // Get into the middle of an add, then clear for 3 cycles.
    fetch("pre");
    drive(1'b0, OP_ADD, GRB | ROUT | YIN | RUN, "pre.T3");
    for (int i = 0; i < 3; i++) drive(1'b1, rnd_op(), 25'd0, "clr_hold");

    do_alu3(OP_ADD, "add");
    do_alu3(OP_SUB, "sub");
    do_alu3(OP_AND, "and");
    do_alu3(OP_OR,  "or");
    do_ld("ld");

    do_muldiv(OP_MUL, "mul");
    do_short(OP_MFHI, ZHIOUT | GRA | RIN, "mfhi");
    do_short(OP_MFLO, ZLOOUT | GRA | RIN, "mflo");
    do_muldiv(OP_DIV, "div");
    do_short(OP_NOP, 25'd0, "nop");

    // addi with the opcode switched to halt while it is in T4
    fetch("addi");
    drive(1'b0, OP_ADDI, GRB | ROUT | YIN | RUN,          "addi.T3");
    drive(1'b0, OP_ADDI, COUT | ZLOIN | alu(OP_ADD) | RUN, "addi.T4");
    drive(1'b0, OP_HALT, ZLOOUT | GRA | RIN | RUN,        "addi.T5");
    drive(1'b0, OP_HALT, E_T0, "halt.T0");
    drive(1'b0, OP_HALT, E_T1, "halt.T1");
    drive(1'b0, OP_HALT, E_T2, "halt.T2");
    drive(1'b0, OP_HALT, RUN,  "halt.T3");
    for (int i = 0; i < 20; i++) drive(1'b0, rnd_op(), 25'd0, "halt_hold");
    drive(1'b1, rnd_op(), 25'd0, "halt_clr");

    do_short(OP_UNK, 25'd0, "unk");
    do_alu3(OP_ADD, "add2");

    // ld interrupted by clear while it is in T4
    fetch("ldc");
    drive(1'b0, OP_LD,    GRB | BAOUT | YIN | RUN,          "ldc.T3");
    drive(1'b0, rnd_op(), COUT | ZLOIN | alu(OP_ADD) | RUN, "ldc.T4");
    drive(1'b1, rnd_op(), 25'd0, "ldc.clr");
    drive(1'b0, rnd_op(), E_T0,  "ldc.rel");

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style sequencing FSM that drives the DataPath control strobes for a Mini-SRC instruction subset. It replaces the hand-driven control sequences used in per-instruction benches. The block sits directly upstream of DataPath: it reads the latched opcode field IR[31:27] and emits one full cycle of strobes per T-state.

## Interface
- No parameters; the opcode map and ALU codes are fixed.
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous, active-high reset.
- opcode  in  5  IR[31:27] from DataPath; sampled only in state T2→T3 transition.
- PCout, IncPC, MARin, MDRin, MDRout, read, RAMenable, IRin  out  1 each  fetch/memory strobes.
- Yin, ZLOin, ZLOout, ZHIout, Cout, BAout  out  1 each  ALU-path strobes.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-select strobes.
- aluControl  out  5  ALU operation code.
- run  out  1  high unless halted or in reset state.

## Operation
- Opcodes: ld 00000, add 00011, sub 00100, and 01010, or 01011, addi 01100, mul 01111, div 10000, mfhi 11000, mflo 11001, nop 11010, halt 11011. Any other value is treated as nop.
- States: RST, T0..T7, HALT. The state register is 4 bits. Outputs are decoded purely from the state register and the registered opcode copy `op_q`.
- `op_q` is captured on the posedge leaving T2, so the IR is valid in T3.
- Every strobe not listed for a state is 0. aluControl is 0 except where stated.
- RST: all outputs 0, run=0. Next state is T0.
- T0: PCout, MARin, IncPC.
- T1: read, RAMenable, MDRin.
- T2: MDRout, IRin.
- add/sub/and/or, three-register form:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLOin, aluControl=op_q.
  - T5: ZLOout, Gra, Rin.
  - Then T0.
- addi:
  - T3: Grb, Rout, Yin.
  - T4: Cout, ZLOin, aluControl=00011.
  - T5: ZLOout, Gra, Rin.
  - Then T0.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ZLOin, aluControl=00011.
  - T5: ZLOout, MARin.
  - T6: read, RAMenable, MDRin.
  - T7: MDRout, Gra, Rin.
  - Then T0.
- mul/div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ZLOin, aluControl=op_q.
  - Then T0. The 64-bit result remains in Z.
- mfhi: T3: ZHIout, Gra, Rin. Then T0.
- mflo: T3: ZLOout, Gra, Rin. Then T0.
- nop/unknown: T3 asserts nothing. Then T0.
- halt: T3 → HALT. HALT has all strobes 0 and run=0, and stays in HALT until clear.

## Timing
- All transitions occur on posedge clock. Each state lasts exactly one cycle, and strobes are stable for the whole cycle.
- Reset:
  - clear=1 at a posedge forces state=RST and op_q=0 on that edge. This applies from any state, including mid-instruction and HALT.
  - clear has priority over every other transition.
  - After the edge where clear is sampled, all outputs are 0 and run=0.
- First fetch: T0 is entered on the first posedge with clear=0.
- Instruction cycle counts, T0 through last state inclusive:
  - add/sub/and/or/addi: 6.
  - ld: 8.
  - mul/div: 5.
  - mfhi/mflo/nop: 4.
  - halt: 4, then HALT.
- opcode changes outside the T2→T3 edge have no effect on the current instruction.
- No strobe is ever asserted in two consecutive states unless listed in both. In particular, ZLOin is never asserted in the same cycle as ZLOout.
- run goes to 1 in the cycle T0 is entered.

## Test plan
- Reset: hold clear 3 cycles from an arbitrary state, then release.
  - During clear: all outputs 0, run=0.
  - First cycle after release: PCout=MARin=IncPC=1.
  - Next two cycles: T1 and T2 strobes exactly as specified.
- add (opcode 00011):
  - Sequence T3 {Grb,Rout,Yin}, T4 {Grc,Rout,ZLOin, aluControl=00011}, T5 {ZLOout,Gra,Rin}.
  - Then T0 at cycle 6.
  - Repeat for sub/and/or with aluControl 00100/01010/01011.
- ld (00000): 8-cycle sequence.
  - aluControl=00011 only in T4.
  - read/RAMenable/MDRin in both T1 and T6.
  - Gra/Rin only in T7.
- mul (01111) followed by mfhi (11000) then mflo (11001):
  - mul is 5 cycles, with ZLOin in T4 and aluControl=01111.
  - mfhi T3 asserts ZHIout,Gra,Rin.
  - mflo T3 asserts ZLOout,Gra,Rin.
  - Total 13 cycles.
- Opcode instability: change opcode to 11011 during T4 of an addi.
  - addi completes normally.
  - Next fetch latches the new opcode, enters HALT after T3, and run drops to 0.
  - HALT persists 20 cycles until clear.
- Unknown opcode 11111: 4-cycle nop with no T3 strobes. Assert clear during T4 of a subsequent ld: RST on the next edge, all strobes 0.
